// File: rtl/ddr3_avl_mem_model.sv
// rtl/ddr3_avl_mem_model.sv - Avalon-MM burst memory model standing in for the DDR3 controller
// Write/read burst FSMs, fall-through read command queue, fixed-latency read pipe, optional LFSR backpressure.
module ddr3_avl_mem_model #(
  parameter int          DATA_W     = 128,
  parameter int          ADDR_W     = 26,
  parameter int          MEM_AW     = 14,
  parameter int          SIZE_W     = 3,
  parameter int          RD_LATENCY = 4,
  parameter int          CMDQ_AW    = 4,
  parameter int          READY_MODE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                avl_clk,
  input  logic                avl_reset,
  output logic                avl_ready,
  input  logic                avl_burstbegin,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic [SIZE_W-1:0]   avl_size,
  input  logic                avl_read_req,
  input  logic                avl_write_req,
  input  logic [DATA_W-1:0]   avl_wdata,
  input  logic [DATA_W/8-1:0] avl_be,
  output logic                avl_rdata_valid,
  output logic [DATA_W-1:0]   avl_rdata,
  output logic                avl_err,
  output logic [31:0]         wr_beat_cnt,
  output logic [31:0]         rd_beat_cnt
);

  localparam int BE_W = DATA_W / 8;
  localparam int QD   = 1 << CMDQ_AW;

  typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  wr_state_t         wr_state, wr_state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [SIZE_W-1:0] wr_left, wr_left_nxt;
  rd_state_t         rd_state, rd_state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [SIZE_W-1:0] rd_left, rd_left_nxt;

  logic [ADDR_W-1:0]  q_addr [0:QD-1];
  logic [SIZE_W-1:0]  q_size [0:QD-1];
  logic [CMDQ_AW-1:0] q_wptr, q_rptr;
  logic [CMDQ_AW:0]   q_cnt;
  logic               q_full, q_empty, q_push, q_pop;

  logic              ready_int;
  logic [15:0]       lfsr;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_widx;
  logic              err_set;
  logic              rd_issue;
  logic [SIZE_W-1:0] req_size;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]     dat_pipe [0:RD_LATENCY-1];

  assign q_full    = (q_cnt == (CMDQ_AW+1)'(QD));
  assign q_empty   = (q_cnt == '0);
  assign avl_ready = ready_int & ~q_full;
  // A zero-length burst is flagged but still moves one beat
  assign req_size  = (avl_size == '0) ? SIZE_W'(1) : avl_size;

  assign avl_rdata_valid = vld_pipe[RD_LATENCY-1];
  assign avl_rdata       = dat_pipe[RD_LATENCY-1];

  always_comb begin
    wr_state_nxt = wr_state;
    wr_addr_nxt  = wr_addr;
    wr_left_nxt  = wr_left;
    mem_we       = 1'b0;
    mem_widx     = wr_addr[MEM_AW-1:0];
    q_push       = 1'b0;
    err_set      = 1'b0;
    if (avl_ready) begin
      case (wr_state)
        WR_IDLE: begin
          if (avl_write_req) begin
            if (avl_burstbegin) begin
              mem_we   = 1'b1;
              mem_widx = avl_addr[MEM_AW-1:0];
              if (avl_size == '0) err_set = 1'b1;
              if (req_size > SIZE_W'(1)) begin
                wr_state_nxt = WR_BURST;
                wr_addr_nxt  = avl_addr + ADDR_W'(1);
                wr_left_nxt  = req_size - SIZE_W'(1);
              end
            end else begin
              err_set = 1'b1;
            end
            // Write wins a collision; the read is discarded
            if (avl_read_req) err_set = 1'b1;
          end else if (avl_read_req && avl_burstbegin) begin
            q_push = 1'b1;
            if (avl_size == '0) err_set = 1'b1;
          end
        end
        WR_BURST: begin
          if (avl_write_req) begin
            mem_we      = 1'b1;
            wr_addr_nxt = wr_addr + ADDR_W'(1);
            wr_left_nxt = wr_left - SIZE_W'(1);
            if (wr_left == SIZE_W'(1)) wr_state_nxt = WR_IDLE;
          end
          if (avl_burstbegin || avl_read_req) err_set = 1'b1;
        end
        default: wr_state_nxt = WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_left_nxt  = rd_left;
    q_pop        = 1'b0;
    rd_issue     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (!q_empty) begin
          q_pop        = 1'b1;
          rd_addr_nxt  = q_addr[q_rptr];
          rd_left_nxt  = q_size[q_rptr];
          rd_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        rd_issue    = 1'b1;
        rd_addr_nxt = rd_addr + ADDR_W'(1);
        rd_left_nxt = rd_left - SIZE_W'(1);
        if (rd_left == SIZE_W'(1)) begin
          // Chain straight into the next queued command without a bubble
          if (!q_empty) begin
            q_pop       = 1'b1;
            rd_addr_nxt = q_addr[q_rptr];
            rd_left_nxt = q_size[q_rptr];
          end else begin
            rd_state_nxt = RD_IDLE;
          end
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge avl_clk or posedge avl_reset) begin
    if (avl_reset) begin
      wr_state    <= WR_IDLE;
      wr_addr     <= '0;
      wr_left     <= '0;
      rd_state    <= RD_IDLE;
      rd_addr     <= '0;
      rd_left     <= '0;
      q_wptr      <= '0;
      q_rptr      <= '0;
      q_cnt       <= '0;
      ready_int   <= 1'b0;
      lfsr        <= LFSR_SEED;
      avl_err     <= 1'b0;
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
      vld_pipe    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_left   <= wr_left_nxt;
      rd_state  <= rd_state_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_left   <= rd_left_nxt;
      if (q_push) q_wptr <= q_wptr + CMDQ_AW'(1);
      if (q_pop)  q_rptr <= q_rptr + CMDQ_AW'(1);
      q_cnt     <= q_cnt + (CMDQ_AW+1)'(q_push) - (CMDQ_AW+1)'(q_pop);
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      ready_int <= (READY_MODE == 0) ? 1'b1 : |lfsr[1:0];
      if (err_set) avl_err <= 1'b1;
      if (mem_we) wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (vld_pipe[RD_LATENCY-1]) rd_beat_cnt <= rd_beat_cnt + 32'd1;
      vld_pipe[0] <= rd_issue;
      dat_pipe[0] <= mem[rd_addr[MEM_AW-1:0]];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive a reset
  always_ff @(posedge avl_clk) begin
    if (q_push) begin
      q_addr[q_wptr] <= avl_addr;
      q_size[q_wptr] <= req_size;
    end
    for (int b = 0; b < BE_W; b++)
      if (mem_we && avl_be[b]) mem[mem_widx][b*8 +: 8] <= avl_wdata[b*8 +: 8];
  end

endmodule

// File: tb/tb_ddr3_avl_mem_model.sv
// tb/tb_ddr3_avl_mem_model.sv - directed and scoreboarded checks of ddr3_avl_mem_model
module tb_ddr3_avl_mem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst0, bb0, rd0, wr0, ready0, rvalid0, err0;
  logic [25:0]  addr0;
  logic [2:0]   size0;
  logic [127:0] wdata0, rdata0;
  logic [15:0]  be0;
  logic [31:0]  wcnt0, rcnt0;

  logic         rst1, bb1, rd1, wr1, ready1, rvalid1, err1;
  logic [25:0]  addr1;
  logic [2:0]   size1;
  logic [31:0]  wdata1, rdata1;
  logic [3:0]   be1;
  logic [31:0]  wcnt1, rcnt1;

  ddr3_avl_mem_model u_dut (
    .avl_clk(clk), .avl_reset(rst0), .avl_ready(ready0), .avl_burstbegin(bb0),
    .avl_addr(addr0), .avl_size(size0), .avl_read_req(rd0), .avl_write_req(wr0),
    .avl_wdata(wdata0), .avl_be(be0), .avl_rdata_valid(rvalid0), .avl_rdata(rdata0),
    .avl_err(err0), .wr_beat_cnt(wcnt0), .rd_beat_cnt(rcnt0)
  );

  ddr3_avl_mem_model #(.DATA_W(32), .MEM_AW(6), .READY_MODE(1)) u_rnd (
    .avl_clk(clk), .avl_reset(rst1), .avl_ready(ready1), .avl_burstbegin(bb1),
    .avl_addr(addr1), .avl_size(size1), .avl_read_req(rd1), .avl_write_req(wr1),
    .avl_wdata(wdata1), .avl_be(be1), .avl_rdata_valid(rvalid1), .avl_rdata(rdata1),
    .avl_err(err1), .wr_beat_cnt(wcnt1), .rd_beat_cnt(rcnt1)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] rq0_data[$];
  int           rq0_cyc[$];
  logic [31:0]  rq1_data[$];
  int low1 = 0;
  int tot1 = 0;

  always @(negedge clk) begin
    if (rvalid0) begin
      rq0_data.push_back(rdata0);
      rq0_cyc.push_back(cyc);
    end
    if (rvalid1) rq1_data.push_back(rdata1);
    if (!rst1) begin
      tot1++;
      if (!ready1) low1++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bb0 = 0; rd0 = 0; wr0 = 0; addr0 = '0; size0 = '0; wdata0 = '0; be0 = '0;
  endtask

  task automatic idle1();
    bb1 = 0; rd1 = 0; wr1 = 0; addr1 = '0; size1 = '0; wdata1 = '0; be1 = '0;
  endtask

  task automatic wait_accept(input bit sel, output int acc_cyc);
    bit ok;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      ok = sel ? ready1 : ready0;
      acc_cyc = cyc;
      step();
      n++;
    end while (!ok && n < 200);
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_beats(input bit sel, input int n);
    int t;
    t = 0;
    while ((sel ? rq1_data.size() : rq0_data.size()) < n && t < 400) begin
      step();
      t++;
    end
    if ((sel ? rq1_data.size() : rq0_data.size()) < n) check("rdata_timeout", 0, 1);
    step();
    step();
  endtask

  task automatic write_burst(input logic [25:0] a, input logic [2:0] sz,
                             input logic [127:0] d0, input logic [15:0] ben);
    int n, acc;
    n = (sz == 0) ? 1 : int'(sz);
    for (int k = 0; k < n; k++) begin
      bb0 = (k == 0); wr0 = 1; addr0 = a; size0 = sz; wdata0 = d0 + 128'(k); be0 = ben;
      wait_accept(0, acc);
    end
    idle0();
  endtask

  task automatic read_cmd(input logic [25:0] a, input logic [2:0] sz, output int acc);
    bb0 = 1; rd0 = 1; addr0 = a; size0 = sz;
    wait_accept(0, acc);
    idle0();
  endtask

  task automatic pulse_reset0();
    rst0 = 1;
    step();
    step();
    rst0 = 0;
    step();
  endtask

  logic [31:0] model [0:63];

  initial begin
    int acc, acc0, pushes, a, sz, wbeats, rbeats, pct;
    #1000000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc0, pushes, a, sz, wbeats, rbeats, pct;
    rst0 = 1; rst1 = 1;
    idle0(); idle1();
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", ready0, 0);
    check("rst_rvalid", rvalid0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_err", err0, 0);
    check("rst_wcnt", wcnt0, 0);
    check("rst_rcnt", rcnt0, 0);
    step();
    rst0 = 0; rst1 = 0;
    step();
    @(negedge clk);
    check("ready_after_rst", ready0, 1);
    step();

    // basic burst and latency
    write_burst(26'h10, 3'd4, 128'hA0, 16'hFFFF);
    read_cmd(26'h10, 3'd4, acc);
    wait_beats(0, 4);
    for (int k = 0; k < 4; k++) begin
      check("burst_data", rq0_data[k], 128'hA0 + 128'(k));
      check("burst_cycle", rq0_cyc[k], acc + 6 + k);
    end
    check("burst_wcnt", wcnt0, 4);
    check("burst_rcnt", rcnt0, 4);
    rq0_data.delete(); rq0_cyc.delete();

    // byte enables
    write_burst(26'h5, 3'd1, {16{8'h11}}, 16'hFFFF);
    write_burst(26'h5, 3'd1, {16{8'hFF}}, 16'h00FF);
    read_cmd(26'h5, 3'd1, acc);
    wait_beats(0, 1);
    check("be_merge", rq0_data[0], {{8{8'h11}}, {8{8'hFF}}});
    rq0_data.delete(); rq0_cyc.delete();

    // back-to-back queued reads
    write_burst(26'h0, 3'd2, 128'hB0, 16'hFFFF);
    write_burst(26'h100, 3'd2, 128'hC0, 16'hFFFF);
    write_burst(26'h200, 3'd2, 128'hD0, 16'hFFFF);
    read_cmd(26'h0, 3'd2, acc0);
    read_cmd(26'h100, 3'd2, acc);
    read_cmd(26'h200, 3'd2, acc);
    wait_beats(0, 6);
    check("q_first_cycle", rq0_cyc[0], acc0 + 6);
    for (int k = 0; k < 6; k++) begin
      check("q_data", rq0_data[k], (k < 2) ? 128'hB0 + 128'(k) : (k < 4) ? 128'hC0 + 128'(k-2) : 128'hD0 + 128'(k-4));
      check("q_contig", rq0_cyc[k], rq0_cyc[0] + k);
    end
    check("q_wcnt", wcnt0, 12);
    check("q_rcnt", rcnt0, 11);
    rq0_data.delete(); rq0_cyc.delete();

    // index wrap at the top of the modelled depth
    write_burst(26'h3FFF, 3'd3, 128'hE0, 16'hFFFF);
    read_cmd(26'h0, 3'd1, acc);
    wait_beats(0, 1);
    check("wrap_idx0", rq0_data[0], 128'hE1);
    rq0_data.delete(); rq0_cyc.delete();
    read_cmd(26'h3FFF, 3'd3, acc);
    wait_beats(0, 3);
    for (int k = 0; k < 3; k++) check("wrap_cross", rq0_data[k], 128'hE0 + 128'(k));
    check("wrap_wcnt", wcnt0, 15);
    check("wrap_rcnt", rcnt0, 15);
    rq0_data.delete(); rq0_cyc.delete();

    // write without burstbegin in idle is dropped
    check("err_clean", err0, 0);
    bb0 = 0; wr0 = 1; addr0 = 26'h30; size0 = 3'd1; wdata0 = 128'h77; be0 = 16'hFFFF;
    wait_accept(0, acc);
    idle0();
    check("nobb_err", err0, 1);
    check("nobb_wcnt", wcnt0, 15);
    pulse_reset0();
    check("err_cleared", err0, 0);

    // size 0 writes one beat
    write_burst(26'h20, 3'd0, 128'h55, 16'hFFFF);
    check("size0_err", err0, 1);
    check("size0_wcnt", wcnt0, 1);
    read_cmd(26'h20, 3'd1, acc);
    wait_beats(0, 1);
    check("size0_data", rq0_data[0], 128'h55);
    rq0_data.delete(); rq0_cyc.delete();
    pulse_reset0();

    // read and write together: write wins
    bb0 = 1; wr0 = 1; rd0 = 1; addr0 = 26'h21; size0 = 3'd1; wdata0 = 128'h66; be0 = 16'hFFFF;
    wait_accept(0, acc);
    idle0();
    repeat (12) step();
    check("collide_no_rdata", rq0_data.size(), 0);
    check("collide_err", err0, 1);
    check("collide_wcnt", wcnt0, 1);
    read_cmd(26'h21, 3'd1, acc);
    wait_beats(0, 1);
    check("collide_data", rq0_data[0], 128'h66);
    rq0_data.delete(); rq0_cyc.delete();

    // reset in the middle of a read burst
    read_cmd(26'h10, 3'd4, acc);
    wait_beats(0, 2);
    rst0 = 1;
    #1;
    check("midrst_rvalid", rvalid0, 0);
    check("midrst_err", err0, 0);
    check("midrst_rcnt", rcnt0, 0);
    rq0_data.delete(); rq0_cyc.delete();
    step();
    step();
    rst0 = 0;
    step();
    step();
    read_cmd(26'h10, 3'd4, acc);
    wait_beats(0, 4);
    check("midrst_beats", rq0_data.size(), 4);
    for (int k = 0; k < 4; k++) check("midrst_retain", rq0_data[k], 128'hA0 + 128'(k));
    rq0_data.delete(); rq0_cyc.delete();

    // fill the command queue with long reads
    pushes = 0;
    bb0 = 1; rd0 = 1; addr0 = 26'h10; size0 = 3'd7;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!ready0) break;
      pushes++;
      step();
    end
    check("qfull_ready", ready0, 0);
    idle0();
    step();
    check("qfull_pushes", pushes, 19);
    for (int t = 0; t < 400 && rcnt0 != 32'd137; t++) step();
    check("qfull_drain_rcnt", rcnt0, 137);
    check("qfull_ready_again", ready0, 1);
    rq0_data.delete(); rq0_cyc.delete();

    // random traffic with backpressure against a scoreboard
    wbeats = 0;
    rbeats = 0;
    for (int op = 0; op < 260; op++) begin
      if (op < 12 || $urandom_range(0, 1) == 1) begin
        a  = (op < 12) ? op * 6 : int'($urandom_range(0, 200));
        sz = (op < 12) ? 6 : int'($urandom_range(1, 7));
        for (int k = 0; k < sz; k++) begin
          bb1 = (k == 0); wr1 = 1; addr1 = 26'(a); size1 = 3'(sz);
          wdata1 = $urandom;
          be1 = (op < 12) ? 4'hF : 4'($urandom_range(0, 15));
          for (int b = 0; b < 4; b++)
            if (be1[b]) model[(a + k) % 64][b*8 +: 8] = wdata1[b*8 +: 8];
          wait_accept(1, acc);
          wbeats++;
        end
        idle1();
      end else begin
        a  = $urandom_range(0, 200);
        sz = $urandom_range(1, 7);
        bb1 = 1; rd1 = 1; addr1 = 26'(a); size1 = 3'(sz);
        wait_accept(1, acc);
        idle1();
        wait_beats(1, sz);
        for (int k = 0; k < sz; k++) check("rnd_rdata", rq1_data[k], model[(a + k) % 64]);
        rbeats += sz;
        rq1_data.delete();
      end
    end
    check("rnd_wcnt", wcnt1, wbeats);
    check("rnd_rcnt", rcnt1, rbeats);
    check("rnd_err", err1, 0);
    pct = (low1 * 100) / tot1;
    check("rnd_ready_low_pct", (pct >= 15 && pct <= 35), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
